// File: rtl/s_add16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit signed adder among NREQ requesters.
// Returns a registered 17-bit sum tagged with the winning requester's ID.
module s_add16_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [16:0]          resp_sum,
    output logic [IDW-1:0]       resp_id,
    output logic                 resp_ovf
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;
    logic           can_accept;
    logic           accept;
    logic [15:0]    a_sel;
    logic [15:0]    b_sel;
    logic [16:0]    sum;

    assign resp_valid = (state == FULL);
    assign can_accept = (state == EMPTY) || resp_ready;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign accept = can_accept && found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[win] = 1'b1;
    end

    assign a_sel = req_a[int'(win)*16 +: 16];
    assign b_sel = req_b[int'(win)*16 +: 16];
    assign sum   = {a_sel[15], a_sel} + {b_sel[15], b_sel};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            resp_sum <= '0;
            resp_id  <= '0;
            resp_ovf <= 1'b0;
        end else if (accept) begin
            state    <= FULL;
            resp_sum <= sum;
            resp_id  <= win;
            resp_ovf <= sum[16] ^ sum[15];
            ptr      <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        end else if (resp_ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_s_add16_rr_arbiter.sv
// Scoreboard bench for s_add16_rr_arbiter: directed vectors push expected
// results; a monitor pops and compares on every output handshake.
module tb_s_add16_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [16*NREQ-1:0]  req_a;
    logic [16*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid;
    logic                resp_ready;
    logic [16:0]         resp_sum;
    logic [IDW-1:0]      resp_id;
    logic                resp_ovf;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    logic [15:0] rr_a[4]   = '{16'h1234, 16'hFFFE, 16'h4000, 16'h8001};
    logic [15:0] rr_b[4]   = '{16'h0001, 16'hFFFD, 16'h4000, 16'hFFFF};
    logic [16:0] rr_sum[4] = '{17'h01235, 17'h1FFFB, 17'h08000, 17'h18000};
    logic        rr_ovf[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic [15:0] sg_a[3]   = '{16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] sg_b[3]   = '{16'h0001, 16'h8000, 16'h0001};
    logic [16:0] sg_sum[3] = '{17'h08000, 17'h10000, 17'h00000};
    logic        sg_ovf[3] = '{1'b1, 1'b1, 1'b0};

    s_add16_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
        .resp_ovf   (resp_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] pack(input logic [16:0] s,
                                         input logic [1:0] id,
                                         input logic o);
        return {s, id, o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a,
                           input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    // Monitor: compare on each resp_valid & resp_ready handshake.
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (resp_valid && resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got %h expected none",
                             {resp_sum, resp_id, resp_ovf});
                end else begin
                    e = exp_q.pop_front();
                    if ({resp_sum, resp_id, resp_ovf} !== e) begin
                        errors++;
                        $display("FAIL resp: got sum=%h id=%0d ovf=%b expected sum=%h id=%0d ovf=%b",
                                 resp_sum, resp_id, resp_ovf,
                                 e[19:3], e[2:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        int id;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        repeat (2) begin
            @(negedge clk);
            #2;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("idle_valid", resp_valid, 0);
            chk("idle_ready", req_ready, 0);
            chk("idle_sum", resp_sum, 0);
            chk("idle_id", resp_id, 0);
            @(negedge clk);
        end

        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0100;
            set_req(2, sg_a[i], sg_b[i]);
            exp_q.push_back(pack(sg_sum[i], 2'd2, sg_ovf[i]));
            #2;
            chk("single_ready", req_ready, 4'b0100);
            @(negedge clk);
        end
        req_valid = '0;
        #2;
        chk("drain_valid_hi", resp_valid, 1);
        @(negedge clk);
        #2;
        chk("drain_valid_lo", resp_valid, 0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            set_req(i, rr_a[i], rr_b[i]);
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            id = k % 4;
            exp_q.push_back(pack(rr_sum[id], 2'(id), rr_ovf[id]));
            #2;
            chk("rr_ready", req_ready, 32'(1 << id));
            if (k > 0)
                chk("rr_no_bubble", resp_valid, 1);
            @(negedge clk);
        end
        req_valid = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            id = (k == 0) ? 3 : 0;
            exp_q.push_back(pack(rr_sum[id], 2'(id), rr_ovf[id]));
            #2;
            chk("rr_skip_ready", req_ready, 32'(1 << id));
            chk("rr_skip_valid", resp_valid, 1);
            @(negedge clk);
        end

        resp_ready = 1'b0;
        req_valid  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", resp_valid, 1);
            chk("bp_sum", resp_sum, rr_sum[0]);
            chk("bp_id", resp_id, 0);
            chk("bp_ovf", resp_ovf, rr_ovf[0]);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        exp_q.push_back(pack(rr_sum[1], 2'd1, rr_ovf[1]));
        #2;
        chk("bp_release_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid  = '0;
        resp_ready = 1'b0;
        #2;
        chk("bp_release_valid", resp_valid, 1);
        chk("bp_release_id", resp_id, 1);

        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1010;
        exp_q.delete();
        #2;
        chk("rst_stall_ready", req_ready, 0);
        @(negedge clk);
        rst        = 1'b0;
        resp_ready = 1'b1;
        exp_q.push_back(pack(rr_sum[1], 2'd1, rr_ovf[1]));
        #2;
        chk("rst_stall_valid", resp_valid, 0);
        chk("rst_first_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #3;
        end
        if (exp_q.size() != 0) begin
            errors += exp_q.size();
            $display("FAIL timeout: got %0d pending results expected 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
